// File: rtl/mul_seq_if.sv
// Handshake and operand/result bundle between the control unit and the multiplier.
interface mul_seq_if #(
  parameter int unsigned BUS_WIDTH = 16
);
  logic                     start;
  logic [BUS_WIDTH-1:0]     a;
  logic [BUS_WIDTH-1:0]     b;
  logic [2*BUS_WIDTH-1:0]   product;
  logic                     busy;
  logic                     done;
  logic                     overflow;

  // Control unit side: issues operands and start, observes result and status.
  modport master (
    output start, a, b,
    input  product, busy, done, overflow
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output product, busy, done, overflow
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-and-add unsigned multiplier: one add per cycle, BUS_WIDTH
// iterations per product, start/busy/done handshake.
module mul_seq #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  mul_seq_if.slave  bus
);

  localparam int unsigned W  = BUS_WIDTH;
  localparam int unsigned SW = W + 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [W-1:0]    mcand_q,    mcand_d;
  logic [W-1:0]    acc_hi_q,   acc_hi_d;
  logic [W-1:0]    acc_lo_q,   acc_lo_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [PW-1:0]   product_q,  product_d;
  logic            overflow_q, overflow_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;

  // {carry, sum} of the iteration adder and the right-shifted accumulator.
  logic [SW-1:0]   add_c;
  logic [PW-1:0]   shifted_c;

  // Next-state, datapath iteration and registered status decode.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    count_d    = count_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    // Carry is kept in the top bit so it shifts into acc_hi, never lost.
    add_c     = SW'(acc_hi_q) + SW'(acc_lo_q[0] ? mcand_q : {W{1'b0}});
    shifted_c = {add_c, acc_lo_q[W-1:1]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_hi_d = shifted_c[PW-1:W];
        acc_lo_d = shifted_c[W-1:0];
        count_d  = count_q + CW'(1);
        // Last iteration: publish the shifted value as the product.
        if (count_q == CW'(W - 1)) begin
          product_d  = shifted_c;
          overflow_d = |shifted_c[PW-1:W];
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; synchronous reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      count_q    <= count_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: reset, arithmetic corners, latency and handshake.
module tb_mul_seq;

  localparam int unsigned W = 16;
  localparam int MAX_WAIT = 40;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mul_seq_if #(.BUS_WIDTH(W)) bus ();

  mul_seq #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the falling edge after acceptance.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges from acceptance until done, bounded; also counts busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.product !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: product=%h busy=%b done=%b ovf=%b, want 0/0/0/0",
               bus.product, bus.busy, bus.done, bus.overflow);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.product !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: product=%h busy=%b done=%b ovf=%b, want all 0",
                 i, bus.product, bus.busy, bus.done, bus.overflow);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(16'd5, 16'd5);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bc !== 16) begin
      n_err++;
      $display("FAIL basic_latency: lat=%0d busy_cycles=%0d, want 16/16", lat, bc);
    end
    n_cmp++;
    if (bus.product !== 32'd25 || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: product=%0d ovf=%b busy=%b, want 25/0/0",
               bus.product, bus.overflow, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", bus.done);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.product !== 32'd25 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL basic_hold[%0d]: product=%0d done=%b busy=%b, want 25/0/0",
                 i, bus.product, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bus.product !== 32'hFFFE0001 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL carry_max: lat=%0d product=%h ovf=%b, want 16/fffe0001/1",
               lat, bus.product, bus.overflow);
    end
    start_op(16'd65534, 16'd1);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bus.product !== 32'd65534 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL carry_ident: lat=%0d product=%0d ovf=%b, want 16/65534/0",
               lat, bus.product, bus.overflow);
    end
    start_op(16'd256, 16'd44);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bus.product !== 32'd11264 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL carry_shift: lat=%0d product=%0d ovf=%b, want 16/11264/0",
               lat, bus.product, bus.overflow);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    start_op(16'd0, 16'hFFFF);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bc !== 16 || bus.product !== 32'd0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL zero_a: lat=%0d busy_cycles=%0d product=%0d ovf=%b, want 16/16/0/0",
               lat, bc, bus.product, bus.overflow);
    end
    start_op(16'd1, 16'd0);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bc !== 16 || bus.product !== 32'd0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL zero_b: lat=%0d busy_cycles=%0d product=%0d ovf=%b, want 16/16/0/0",
               lat, bc, bus.product, bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    // start held high; operands changed after acceptance must be ignored
    @(negedge clk);
    bus.a     = 16'd3;
    bus.b     = 16'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 16'd9;
    bus.b = 16'd11;
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bus.product !== 32'd21 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL held_start: lat=%0d product=%0d ovf=%b, want 16/21/0",
               lat, bus.product, bus.overflow);
    end
    // start still high during DONE: immediate restart with new operands
    bus.a = 16'd300;
    bus.b = 16'd300;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== 32'd21) begin
      n_err++;
      $display("FAIL restart: busy=%b done=%b product=%0d, want 1/0/21",
               bus.busy, bus.done, bus.product);
    end
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bc !== 16 || bus.product !== 32'h00015F90 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL restart_result: lat=%0d busy_cycles=%0d product=%h ovf=%b, want 16/16/00015f90/1",
               lat, bc, bus.product, bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, done_seen;
    start_op(16'd1000, 16'd1000);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'd0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h ovf=%b, want 0/0/0/0",
               bus.busy, bus.done, bus.product, bus.overflow);
    end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL reset_discard: busy/done seen %0d cycles, want 0", done_seen);
    end
    // reset and start together: reset wins
    bus.a     = 16'd2;
    bus.b     = 16'd2;
    bus.start = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.product !== 32'd0) begin
      n_err++;
      $display("FAIL reset_vs_start: busy=%b product=%0d, want 0/0", bus.busy, bus.product);
    end
    start_op(16'd12, 16'd12);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 16 || bc !== 16 || bus.product !== 32'd144 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset: lat=%0d busy_cycles=%0d product=%0d ovf=%b, want 16/16/144/0",
               lat, bc, bus.product, bus.overflow);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
